// File: rtl/vedic_dot_accum_pkg.sv
// Shared types and constants for the Vedic dot-product accumulator.
package vedic_dot_accum_pkg;

    localparam int PROD_W      = 64;
    localparam int DEF_N_TERMS = 4;
    localparam int DEF_ACC_W   = 72;
    localparam int DEF_CNT_W   = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } dot_state_e;

    // Smallest accumulator that can hold n_terms full-scale products without wrapping.
    function automatic int min_acc_w(input int n_terms);
        return PROD_W + $clog2(n_terms);
    endfunction

endpackage

// File: rtl/vedic_dot_accum_if.sv
// Product input / sum output bundle of the dot-product accumulator.
interface vedic_dot_accum_if
    import vedic_dot_accum_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W,
    parameter int CNT_W = DEF_CNT_W
);
    logic              start;
    logic [PROD_W-1:0] prod_in;
    logic              prod_valid;
    logic [ACC_W-1:0]  sum_out;
    logic              sum_valid;
    logic              sum_ready;
    logic              busy;
    logic [CNT_W-1:0]  term_cnt;
    logic              err_overrun;
    logic              err_stray;
    logic              err_clr;

    modport master (
        output start, prod_in, prod_valid, sum_ready, err_clr,
        input  sum_out, sum_valid, busy, term_cnt, err_overrun, err_stray
    );

    modport slave (
        input  start, prod_in, prod_valid, sum_ready, err_clr,
        output sum_out, sum_valid, busy, term_cnt, err_overrun, err_stray
    );

endinterface

// File: rtl/vedic_dot_outreg.sv
// Valid/ready holding register that never stalls its producer; a load that
// finds the register occupied is dropped and raises a sticky overrun flag.
module vedic_dot_outreg #(
    parameter int W = 72
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    input  logic         clr_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic         overrun_o
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         overrun_q, overrun_d;
    logic         accept_s;
    logic         drop_s;

    // Next-state for the holding register and its sticky overrun flag.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        accept_s  = valid_q && ready_i;
        drop_s    = load_i && valid_q && !ready_i;

        if (load_i && !drop_s) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end else if (accept_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        // A new drop beats a same-cycle clear.
        if (drop_s) begin
            overrun_d = 1'b1;
        end else if (clr_i) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q    <= {W{1'b0}};
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/vedic_dot_accum.sv
// Accumulates N_TERMS 64-bit products per dot product into a held output.
// Optional: VEDIC_DOT_AUTORESTART_EN re-enters ACCUM after each completion.
module vedic_dot_accum
    import vedic_dot_accum_pkg::*;
#(
    parameter int N_TERMS = DEF_N_TERMS,
    parameter int ACC_W   = DEF_ACC_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    vedic_dot_accum_if.slave  bus
);

    if (N_TERMS < 1 || N_TERMS > 256) begin : g_bad_n_terms
        $error("vedic_dot_accum: N_TERMS must be in 1..256");
    end
    if (ACC_W < min_acc_w(N_TERMS)) begin : g_bad_acc_w
        $error("vedic_dot_accum: ACC_W too narrow for N_TERMS");
    end
    if ((2 ** CNT_W) < N_TERMS) begin : g_bad_cnt_w
        $error("vedic_dot_accum: CNT_W too narrow for N_TERMS");
    end

    localparam logic [CNT_W:0] LAST_CNT = (CNT_W + 1)'(N_TERMS);

    dot_state_e       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stray_q, stray_d;

    logic             in_row_s;
    logic             stray_ev_s;
    logic             done_s;
    logic [ACC_W-1:0] final_sum_s;
    logic [ACC_W-1:0] prod_ext_s;
    logic [ACC_W-1:0] base_acc_s;
    logic [ACC_W-1:0] sum_s;
    logic [CNT_W:0]   base_cnt_s;
    logic [CNT_W:0]   next_cnt_s;

    assign prod_ext_s = ACC_W'(bus.prod_in);

    // Next-state logic: row entry/restart, term accumulation and completion.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        stray_d     = stray_q;
        in_row_s    = 1'b0;
        stray_ev_s  = 1'b0;
        done_s      = 1'b0;
        final_sum_s = {ACC_W{1'b0}};

        case (state_q)
            ST_IDLE: begin
                in_row_s   = bus.start;
                stray_ev_s = bus.prod_valid && !bus.start;
            end
            ST_ACCUM: begin
                in_row_s = 1'b1;
            end
            default: begin
                in_row_s = 1'b0;
            end
        endcase

        // start discards any partial sum; a same-cycle product becomes term 1.
        if (bus.start) begin
            base_acc_s = {ACC_W{1'b0}};
            base_cnt_s = {(CNT_W + 1){1'b0}};
        end else begin
            base_acc_s = acc_q;
            base_cnt_s = {1'b0, cnt_q};
        end
        sum_s      = base_acc_s + prod_ext_s;
        next_cnt_s = base_cnt_s + {{CNT_W{1'b0}}, 1'b1};

        if (in_row_s) begin
            state_d = ST_ACCUM;
            if (bus.prod_valid && (next_cnt_s == LAST_CNT)) begin
                done_s      = 1'b1;
                final_sum_s = sum_s;
                acc_d       = {ACC_W{1'b0}};
                cnt_d       = {CNT_W{1'b0}};
`ifdef VEDIC_DOT_AUTORESTART_EN
                state_d     = ST_ACCUM;
`else
                state_d     = ST_IDLE;
`endif
            end else if (bus.prod_valid) begin
                acc_d = sum_s;
                cnt_d = next_cnt_s[CNT_W-1:0];
            end else begin
                acc_d = base_acc_s;
                cnt_d = base_cnt_s[CNT_W-1:0];
            end
        end else begin
            state_d = ST_IDLE;
        end

        if (stray_ev_s) begin
            stray_d = 1'b1;
        end else if (bus.err_clr) begin
            stray_d = 1'b0;
        end else begin
            stray_d = stray_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            acc_q   <= {ACC_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            stray_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            stray_q <= stray_d;
        end
    end

    vedic_dot_outreg #(
        .W (ACC_W)
    ) u_outreg (
        .clk       (clk),
        .reset     (reset),
        .load_i    (done_s),
        .data_i    (final_sum_s),
        .ready_i   (bus.sum_ready),
        .clr_i     (bus.err_clr),
        .data_o    (bus.sum_out),
        .valid_o   (bus.sum_valid),
        .overrun_o (bus.err_overrun)
    );

    assign bus.busy      = (state_q == ST_ACCUM);
    assign bus.term_cnt  = cnt_q;
    assign bus.err_stray = stray_q;

endmodule

// File: tb/tb_vedic_dot_accum.sv
// Directed bench for vedic_dot_accum with a row-level reference model.
module tb_vedic_dot_accum;
    import vedic_dot_accum_pkg::*;

    localparam int N_TERMS = 4;
    localparam int ACC_W   = 72;
    localparam int CNT_W   = 8;
`ifdef VEDIC_DOT_AUTORESTART_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    vedic_dot_accum_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    vedic_dot_accum #(
        .N_TERMS (N_TERMS),
        .ACC_W   (ACC_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: one row in flight, a plain running sum and term count.
    bit               m_active = 1'b0;
    logic [ACC_W-1:0] m_sum    = '0;
    int               m_cnt    = 0;
    logic [ACC_W-1:0] e_sum    = '0;
    bit               e_valid  = 1'b0;
    bit               e_ovr    = 1'b0;
    bit               e_stray  = 1'b0;

    task automatic check(input string name, input logic [ACC_W-1:0] act, input logic [ACC_W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit               done;
        bit               stray_now;
        bit               ovr_now;
        logic [ACC_W-1:0] fin;
        done      = 1'b0;
        stray_now = 1'b0;
        fin       = '0;
        if (reset) begin
            m_active = 1'b0; m_sum = '0; m_cnt = 0;
            e_sum = '0; e_valid = 1'b0; e_ovr = 1'b0; e_stray = 1'b0;
            return;
        end
        if (bus.start) begin
            m_active = 1'b1; m_sum = '0; m_cnt = 0;
        end
        if (bus.prod_valid) begin
            if (m_active) begin
                m_sum = m_sum + ACC_W'(bus.prod_in);
                m_cnt++;
                if (m_cnt == N_TERMS) begin
                    done = 1'b1; fin = m_sum;
                    m_sum = '0; m_cnt = 0; m_active = AUTO;
                end
            end else begin
                stray_now = 1'b1;
            end
        end
        ovr_now = done && e_valid && !bus.sum_ready;
        if (done && !ovr_now) begin
            e_sum = fin; e_valid = 1'b1;
        end else if (e_valid && bus.sum_ready) begin
            e_valid = 1'b0;
        end
        if (bus.err_clr) begin
            e_ovr = 1'b0; e_stray = 1'b0;
        end
        if (ovr_now)   e_ovr   = 1'b1;
        if (stray_now) e_stray = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            model_step();
        end
    end

    // Every-cycle comparison against the model, on the inactive edge.
    initial begin
        forever begin
            @(negedge clk);
            check("sum_valid",   ACC_W'(bus.sum_valid),   ACC_W'(e_valid));
            check("sum_out",     bus.sum_out,             e_sum);
            check("busy",        ACC_W'(bus.busy),        ACC_W'(m_active));
            check("term_cnt",    ACC_W'(bus.term_cnt),    ACC_W'(m_cnt));
            check("err_overrun", ACC_W'(bus.err_overrun), ACC_W'(e_ovr));
            check("err_stray",   ACC_W'(bus.err_stray),   ACC_W'(e_stray));
        end
    end

    task automatic drive(input bit st, input bit pv, input logic [63:0] p);
        bus.start      = st;
        bus.prod_valid = pv;
        bus.prod_in    = p;
        @(posedge clk);
        #1;
        bus.start      = 1'b0;
        bus.prod_valid = 1'b0;
        bus.prod_in    = 64'd0;
    endtask

    task automatic row(input logic [63:0] v);
        drive(1'b1, 1'b0, 64'd0);
        for (int i = 0; i < N_TERMS; i++) drive(1'b0, 1'b1, v);
    endtask

    initial begin
        bus.start = 1'b0; bus.prod_valid = 1'b0; bus.prod_in = 64'd0;
        bus.sum_ready = 1'b1; bus.err_clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 64'd0);

        // Stray product in IDLE, then clear racing a second stray.
        drive(1'b0, 1'b1, 64'd9);
        check("stray_set", ACC_W'(bus.err_stray), ACC_W'(1'b1));
        check("stray_cnt", ACC_W'(bus.term_cnt), ACC_W'(0));
        bus.err_clr = 1'b1;
        drive(1'b0, 1'b1, 64'd5);
        check("stray_clr_race", ACC_W'(bus.err_stray), ACC_W'(1'b1));
        drive(1'b0, 1'b0, 64'd0);
        bus.err_clr = 1'b0;
        check("stray_clr", ACC_W'(bus.err_stray), ACC_W'(1'b0));

        // 1+2+3+4
        drive(1'b1, 1'b0, 64'd0);
        drive(1'b0, 1'b1, 64'd1);
        drive(1'b0, 1'b1, 64'd2);
        drive(1'b0, 1'b1, 64'd3);
        check("sum10_latency", ACC_W'(bus.sum_valid), ACC_W'(1'b0));
        drive(1'b0, 1'b1, 64'd4);
        check("sum10_valid", ACC_W'(bus.sum_valid), ACC_W'(1'b1));
        check("sum10", bus.sum_out, 72'd10);
        check("sum10_model", e_sum, 72'd10);
        check("sum10_cnt", ACC_W'(bus.term_cnt), ACC_W'(0));
        if (!AUTO) check("sum10_busy", ACC_W'(bus.busy), ACC_W'(1'b0));

        // Full-scale products must not wrap.
        row(64'hFFFF_FFFF_FFFF_FFFF);
        check("max_sum", bus.sum_out, 72'h3_FFFF_FFFF_FFFF_FFFC);
        check("max_model", e_sum, 72'h3_FFFF_FFFF_FFFF_FFFC);

        // Overrun: second sum dropped while the first is unaccepted.
        drive(1'b0, 1'b0, 64'd0);
        bus.sum_ready = 1'b0;
        row(64'd1);
        row(64'd2);
        check("ovr_hold", bus.sum_out, 72'd4);
        check("ovr_flag", ACC_W'(bus.err_overrun), ACC_W'(1'b1));
        bus.err_clr = 1'b1;
        drive(1'b0, 1'b0, 64'd0);
        bus.err_clr = 1'b0;
        check("ovr_clr", ACC_W'(bus.err_overrun), ACC_W'(1'b0));
        check("ovr_still_valid", ACC_W'(bus.sum_valid), ACC_W'(1'b1));
        check("ovr_still_sum", bus.sum_out, 72'd4);

        // Completion coincides with accept: reload, no error.
        drive(1'b1, 1'b0, 64'd0);
        drive(1'b0, 1'b1, 64'd3);
        drive(1'b0, 1'b1, 64'd3);
        drive(1'b0, 1'b1, 64'd3);
        bus.sum_ready = 1'b1;
        drive(1'b0, 1'b1, 64'd3);
        check("reload_sum", bus.sum_out, 72'd12);
        check("reload_valid", ACC_W'(bus.sum_valid), ACC_W'(1'b1));
        check("reload_no_ovr", ACC_W'(bus.err_overrun), ACC_W'(1'b0));
        drive(1'b0, 1'b0, 64'd0);
        check("accept_drop_valid", ACC_W'(bus.sum_valid), ACC_W'(1'b0));
        check("accept_keep_sum", bus.sum_out, 72'd12);

        // Restart mid-row with a same-cycle product.
        drive(1'b1, 1'b0, 64'd0);
        drive(1'b0, 1'b1, 64'd5);
        drive(1'b0, 1'b1, 64'd6);
        drive(1'b1, 1'b1, 64'd7);
        drive(1'b0, 1'b1, 64'd1);
        drive(1'b0, 1'b1, 64'd1);
        drive(1'b0, 1'b1, 64'd1);
        check("restart_sum", bus.sum_out, 72'd10);
        check("restart_no_ovr", ACC_W'(bus.err_overrun), ACC_W'(1'b0));
        check("restart_no_stray", ACC_W'(bus.err_stray), ACC_W'(1'b0));

        // Asynchronous reset between clock edges, mid-row.
        drive(1'b1, 1'b0, 64'd0);
        drive(1'b0, 1'b1, 64'd5);
        drive(1'b0, 1'b1, 64'd5);
        check("pre_rst_busy", ACC_W'(bus.busy), ACC_W'(1'b1));
        check("pre_rst_cnt", ACC_W'(bus.term_cnt), ACC_W'(2));
        #2;
        reset = 1'b1;
        #1;
        check("rst_busy", ACC_W'(bus.busy), ACC_W'(1'b0));
        check("rst_cnt", ACC_W'(bus.term_cnt), ACC_W'(0));
        check("rst_sum", bus.sum_out, 72'd0);
        check("rst_valid", ACC_W'(bus.sum_valid), ACC_W'(1'b0));
        check("rst_flags", ACC_W'({bus.err_overrun, bus.err_stray}), ACC_W'(2'b00));
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 1'b0, 64'd0);

`ifdef VEDIC_DOT_AUTORESTART_EN
        // One start streams two rows.
        drive(1'b1, 1'b0, 64'd0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 64'd1);
        check("auto_sum1", bus.sum_out, 72'd4);
        check("auto_busy1", ACC_W'(bus.busy), ACC_W'(1'b1));
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 64'd1);
        check("auto_sum2", bus.sum_out, 72'd4);
        check("auto_valid2", ACC_W'(bus.sum_valid), ACC_W'(1'b1));
        check("auto_no_stray", ACC_W'(bus.err_stray), ACC_W'(1'b0));
`else
        // Without start, products after a completed row are stray.
        row(64'd2);
        check("row8_sum", bus.sum_out, 72'd8);
        drive(1'b0, 1'b1, 64'd1);
        check("post_row_stray", ACC_W'(bus.err_stray), ACC_W'(1'b1));
`endif
        drive(1'b0, 1'b0, 64'd0);
        drive(1'b0, 1'b0, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/vedic_dot_accum.md
Name: vedic_dot_accum

Overview:
- Downstream consumer of the 32x32 Vedic multiplier in the matrix-multiplier datapath.
- Accumulates N_TERMS successive 64-bit unsigned products into one dot-product sum, one matrix result element per sum.
- Presents each sum in a held output register with a valid/ready handshake.
- The multiplier pipeline cannot stall, so the block never back-pressures products. It flags lost or stray data instead.

Parameters:
- N_TERMS, 4, products per dot product (matrix inner dimension); legal range 1..256.
- ACC_W, 72, accumulator/output width; must be >= 64+clog2(N_TERMS); elaboration error otherwise.
- CNT_W, 8, term counter width; must satisfy 2**CNT_W >= N_TERMS.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; begins (or restarts) a dot product
- prod_in  in  64  unsigned product from multiplier result
- prod_valid  in  1  one-cycle qualifier for prod_in (multiplier done)
- sum_out  out  ACC_W  completed dot-product sum
- sum_valid  out  1  sum_out holds an unaccepted result
- sum_ready  in  1  consumer accepts sum_out when high with sum_valid
- busy  out  1  high in ACCUM state
- term_cnt  out  CNT_W  products accumulated in current dot product
- err_overrun  out  1  sticky: a sum completed while the output was still occupied; that sum was dropped
- err_stray  out  1  sticky: prod_valid arrived in IDLE without start
- err_clr  in  1  synchronous clear of both sticky flags

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high. It forces every output and register to 0 and the FSM to IDLE, including mid-accumulation; any partial sum is discarded.
- States:
  - IDLE: busy=0.
  - ACCUM: busy=1; holds acc and term_cnt.
- Accumulation: fully unsigned, zero-extended, width ACC_W; no overflow is possible by the parameter rule.
- IDLE behaviour:
  - start=1 with prod_valid=0: go to ACCUM, acc=0, term_cnt=0.
  - start=1 with prod_valid=1: the product is term 1 (acc=prod_in, term_cnt=1).
  - prod_valid=1 without start: product ignored, err_stray set.
- ACCUM behaviour:
  - Each prod_valid does acc+=prod_in and term_cnt+=1.
  - start=1 in ACCUM aborts the current sum and restarts as in IDLE, with the same-cycle product counted as term 1. No error is flagged.
- Completion:
  - Occurs on the cycle prod_valid carries term N_TERMS.
  - The final sum (acc+prod_in) goes to the output register, the FSM returns to IDLE, and term_cnt becomes 0.
  - Latency: sum_valid rises the cycle after the last prod_valid.
  - N_TERMS=1: start+prod_valid together complete in that same cycle.
- Output handshake:
  - sum_out and sum_valid stay stable until sum_valid&&sum_ready.
  - sum_out does not change while sum_valid=1 except on accept-and-reload.
  - Accept with no new completion: sum_valid=0 next cycle; sum_out keeps its last value.
  - Completion while sum_valid=1 and sum_ready=0: the new sum is dropped, err_overrun is set, and the old sum is retained.
  - Completion in the same cycle as accept: the new sum loads, sum_valid stays 1, no error.
- err_clr: clears both flags. If err_clr coincides with a new error event, the error wins (flag ends 1).

Optional Feature:
- Macro: VEDIC_DOT_AUTORESTART_EN
- Defined: after completion the FSM goes straight back to ACCUM with acc=0 and term_cnt=0. Back-to-back rows stream without start pulses, and err_stray never fires after the first start.
- Undefined: the FSM returns to IDLE and each dot product needs a start pulse.

Decomposition:
- Shared package holds:
  - state enum (IDLE, ACCUM)
  - default N_TERMS and product width constant (64)
  - function computing minimum ACC_W from N_TERMS
- One sub-module is natural: vedic_dot_outreg, the ACC_W-wide valid/ready holding register with overrun detection. It is reusable for the other adder/buffer outputs.

Test Plan:
- N_TERMS=4; start, then products 1,2,3,4 on separate cycles with sum_ready=1 -> sum_out=10 with sum_valid one cycle after the 4th prod_valid; busy low afterwards.
- Four products of 64'hFFFF_FFFF_FFFF_FFFF -> sum_out=72'h3_FFFF_FFFF_FFFF_FFFC, no wrap.
- Two complete sums with sum_ready=0 -> first sum held, second dropped, err_overrun=1; err_clr -> flag 0, first sum still valid.
- start, products 5,6, then start together with product 7, then 1,1,1 -> sum_out=10, no error.
- prod_valid in IDLE -> err_stray=1, term_cnt=0; async reset asserted mid-accumulation between clock edges -> all outputs 0 immediately.
- With VEDIC_DOT_AUTORESTART_EN: one start, then 8 products of value 1 -> two sums of 4, no err_stray.
